filter_sync_scheduler: RTL



---
 rtl/filter_sync_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/filter_sync_scheduler.sv
// filter_sync_scheduler
// Round-robin scheduler that loads one requester's payload onto a shared
// filter-synchronizer bus and holds it stable for a fixed number of clocks.
// The bus word is {toggle, id, data}. The toggle flips on every transfer, so
// back-to-back identical payloads stay distinguishable after synchronization.
// Optional feature macro: FSS_HOLD_CFG_EN adds a hold_cfg input. That input
// sets the hold length of each transfer. It is sampled at the arbitration edge.
module filter_sync_scheduler #(
    parameter int  NUM_REQ     = 4,
    parameter int  DATA_WIDTH  = 4,
    parameter int  HOLD_CYCLES = 8,
    localparam int ID_W        = $clog2(NUM_REQ),
    localparam int CNT_W       = $clog2(HOLD_CYCLES + 1),
    localparam int BUS_W       = 1 + ID_W + DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef FSS_HOLD_CFG_EN
    input  logic [CNT_W-1:0]              hold_cfg,
`endif
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [BUS_W-1:0]              bus_out,
    output logic                          busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       winner_q, winner_d;
    logic                  toggle_q, toggle_d;
    logic [BUS_W-1:0]      bus_q, bus_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic                  busy_q, busy_d;

    logic                  found_s;
    logic [ID_W-1:0]       winner_s;
    logic [DATA_WIDTH-1:0] win_data_s;
    logic [CNT_W-1:0]      hold_len_s;

    // One-hot decode of a requester ID.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        return NUM_REQ'(1) << id;
    endfunction

`ifdef FSS_HOLD_CFG_EN
    // A zero hold length cannot be represented, so it is stretched to one clock.
    assign hold_len_s = (hold_cfg == {CNT_W{1'b0}}) ? CNT_W'(1) : hold_cfg;
`else
    assign hold_len_s = CNT_W'(HOLD_CYCLES);
`endif

    // Round-robin search: first set request at or above the pointer, with wrap.
    always_comb begin
        found_s  = 1'b0;
        winner_s = {ID_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_s && req[(int'(ptr_q) + i) % NUM_REQ]) begin
                found_s  = 1'b1;
                winner_s = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            end else begin
                found_s  = found_s;
            end
        end
    end

    assign win_data_s = req_data[int'(winner_s)*DATA_WIDTH +: DATA_WIDTH];

    // Next-state and registered-output logic for the IDLE/HOLD controller.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        toggle_d = toggle_q;
        bus_d    = bus_q;
        cnt_d    = cnt_q;
        gnt_d    = {NUM_REQ{1'b0}};
        done_d   = {NUM_REQ{1'b0}};
        busy_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d  = ST_HOLD;
                    winner_d = winner_s;
                    toggle_d = ~toggle_q;
                    bus_d    = {~toggle_q, winner_s, win_data_s};
                    cnt_d    = hold_len_s - CNT_W'(1);
                    gnt_d    = onehot(winner_s);
                    busy_d   = 1'b1;
                    // A one-clock hold completes in the same cycle as the grant.
                    done_d   = (cnt_d == {CNT_W{1'b0}}) ? onehot(winner_s)
                                                        : {NUM_REQ{1'b0}};
                    ptr_d    = (winner_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}}
                                                                : winner_s + ID_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    // Return to IDLE for at least one clock before the next grant.
                    state_d = ST_IDLE;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    busy_d = 1'b1;
                    done_d = (cnt_d == {CNT_W{1'b0}}) ? onehot(winner_q)
                                                      : {NUM_REQ{1'b0}};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= {ID_W{1'b0}};
            winner_q <= {ID_W{1'b0}};
            toggle_q <= 1'b0;
            bus_q    <= {BUS_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            gnt_q    <= {NUM_REQ{1'b0}};
            done_q   <= {NUM_REQ{1'b0}};
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            toggle_q <= toggle_d;
            bus_q    <= bus_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign bus_out = bus_q;
    assign busy    = busy_q;

endmodule
